bbcore_seq: RTL and testbench
=============================

Name: bbcore_seq

Overview:
- Tile-level sequencer for the BitBlade 2b core.
- Accepts a job consisting of an accumulation length and act/weight precision codes.
- Pulls operand beats from the operand buffers through a valid/request handshake. On the first beat it drives the core's bias-select, and after the last beat it drives the core's flush.
- Waits for the core's done, then presents the result as a valid/ready handshake to the psum writeback path.

Parameters:
- K_W, 16, width of the accumulation-step count and the step counter.
- DONE_TO, 64, maximum number of cycles WAIT_DONE waits for i_Core_Done (used only with the optional feature).

Ports:
- CLK  in  1  clock; every flop is rising-edge.
- RST  in  1  asynchronous, active-low reset.
- i_Start  in  1  job start pulse.
- i_Num_Step  in  K_W  number of operand beats to accumulate; must be at least 1.
- i_Act_Prec  in  2  activation precision code.
- i_Wgt_Prec  in  2  weight precision code.
- o_Busy  out  1  high whenever the state is not IDLE.
- o_Op_Req  out  1  requests an operand beat from the buffers.
- i_Op_Valid  in  1  operand beat is present on the core inputs.
- o_Core_En  out  1  a beat transfer occurs this cycle (o_Op_Req & i_Op_Valid).
- o_Core_Sel_Bias  out  1  drives the core's i_Sel_Bias.
- o_Core_Flush  out  1  drives the core's i_Flush.
- o_Core_Precision  out  4  {act_prec, wgt_prec}, latched at job start.
- i_Core_Done  in  1  the core's o_Done.
- o_Psum_Valid  out  1  core psum is valid for writeback.
- i_Psum_Ready  in  1  writeback accepts the psum.
- o_Step_Cnt  out  K_W  number of beats transferred so far in the current job.
- o_Err  out  1  one-cycle error pulse.

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE; every output is 0; o_Core_Precision=0; counter=0.
- States: IDLE, FETCH, FLUSH, WAIT_DONE, OUT.
- IDLE:
  - i_Start=1 with i_Num_Step>=1: latch the step count and both precision codes, clear the counter, go to FETCH on the next cycle.
  - i_Start=1 with i_Num_Step=0: pulse o_Err for one cycle, stay in IDLE.
  - i_Start outside IDLE is ignored.
- FETCH:
  - o_Op_Req=1.
  - A transfer occurs when o_Op_Req & i_Op_Valid; o_Core_En follows that expression combinationally.
  - o_Core_Sel_Bias=1 combinationally on the transfer where the counter is 0. It is 0 otherwise, including while stalled waiting for valid.
  - The counter increments on each transfer.
  - On the transfer that makes the counter equal to the step count, go to FLUSH. o_Op_Req is 0 in the following cycle.
  - When the step count is 1, a single transfer carries both sel_bias and the last beat.
- FLUSH: o_Core_Flush=1 for exactly one cycle, then go to WAIT_DONE.
- WAIT_DONE: stay until i_Core_Done=1, then go to OUT on the next cycle.
- i_Core_Done in any state other than WAIT_DONE is ignored, including done arriving in the FLUSH cycle itself.
- OUT:
  - o_Psum_Valid=1 and stays high until i_Psum_Ready=1 is sampled. No drop or change while waiting.
  - On the handshake, go to IDLE.
  - A new i_Start in the handshake cycle is ignored; start is accepted only once back in IDLE.
- o_Core_Precision holds its latched value from job start until the next accepted start, including in IDLE. Mid-job changes on the precision inputs have no effect.
- o_Step_Cnt shows the live counter and holds its final value in IDLE.
- Reset mid-job: immediate return to IDLE with no flush issued. The core is reset by the same RST.
- Latency with i_Op_Valid held high:
  - start accepted at cycle 0;
  - beats transfer at cycles 1..N;
  - flush at cycle N+1;
  - o_Psum_Valid asserts one cycle after done is sampled.

Optional Feature:
- BBSEQ_DONE_TIMEOUT_EN defined:
  - WAIT_DONE counts its cycles.
  - If DONE_TO cycles pass without i_Core_Done, pulse o_Err for one cycle, set a sticky timeout flag readable on o_Step_Cnt[K_W-1], and go to IDLE with no OUT phase.
  - The sticky flag clears on the next accepted start.
- Not defined: WAIT_DONE waits indefinitely and o_Step_Cnt is purely the beat count.

Test Plan:
- Start with N=4, precision 2'b01 / 2'b10, valid held high → beats on cycles 1–4; sel_bias only on cycle 1; flush on cycle 5; o_Core_Precision=4'b0110; with done at cycle 8, psum valid on cycle 9; ready on cycle 9 → IDLE at cycle 10.
- N=3 with i_Op_Valid toggling 1,0,0,1,0,1 → exactly 3 o_Core_En pulses; sel_bias coincides with the first pulse only; flush one cycle after the third; o_Step_Cnt=3.
- N=1 → a single beat with sel_bias=1; flush the next cycle; o_Step_Cnt=1.
- Start with N=0 → o_Err pulses for one cycle; o_Busy stays 0; no o_Op_Req.
- Backpressure: hold i_Psum_Ready=0 for 10 cycles in OUT and pulse i_Start and i_Core_Done meanwhile → o_Psum_Valid stays 1, state unchanged, start ignored; ready=1 → IDLE.
- Assert RST=0 mid-FETCH (counter=2) → all outputs 0 immediately; after release, a new start with N=2 runs cleanly. With BBSEQ_DONE_TIMEOUT_EN and DONE_TO=64, withholding done → o_Err pulses 64 cycles after entering WAIT_DONE, then IDLE.

Source files
------------

// File: rtl/bbcore_seq.sv
// bbcore_seq: tile-level sequencer for the BitBlade 2b core.
//
// Accepts a job (beat count plus act/weight precision codes), pulls operand
// beats through a req/valid handshake, marks the first beat with bias-select,
// flushes the core after the last beat, waits for the core's done and then
// offers the psum to writeback through a valid/ready handshake.
//
// Ports:
//   CLK, RST           clock (rising edge), asynchronous active-low reset
//   i_Start            job start pulse (honoured only in IDLE)
//   i_Num_Step         operand beats in the job, must be >= 1
//   i_Act_Prec/Wgt     precision codes, latched at job start
//   o_Busy             state is not IDLE
//   o_Op_Req           operand beat request
//   i_Op_Valid         operand beat present
//   o_Core_En          beat transfer this cycle
//   o_Core_Sel_Bias    first beat of the job
//   o_Core_Flush       one-cycle flush after the last beat
//   o_Core_Precision   {act_prec, wgt_prec} of the current/last job
//   i_Core_Done        core finished (only sampled in WAIT_DONE)
//   o_Psum_Valid       psum ready for writeback
//   i_Psum_Ready       writeback accepts the psum
//   o_Step_Cnt         beats transferred so far in the current job
//   o_Err              one-cycle error pulse
//
// Optional feature, macro BBSEQ_DONE_TIMEOUT_EN: WAIT_DONE gives up after
// DONE_TO cycles, pulses o_Err, and raises a sticky flag on o_Step_Cnt[K_W-1]
// that clears on the next accepted start.

module bbcore_seq #(
    parameter int unsigned K_W     = 16,
    parameter int unsigned DONE_TO = 64
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           i_Start,
    input  logic [K_W-1:0] i_Num_Step,
    input  logic [1:0]     i_Act_Prec,
    input  logic [1:0]     i_Wgt_Prec,
    output logic           o_Busy,
    output logic           o_Op_Req,
    input  logic           i_Op_Valid,
    output logic           o_Core_En,
    output logic           o_Core_Sel_Bias,
    output logic           o_Core_Flush,
    output logic [3:0]     o_Core_Precision,
    input  logic           i_Core_Done,
    output logic           o_Psum_Valid,
    input  logic           i_Psum_Ready,
    output logic [K_W-1:0] o_Step_Cnt,
    output logic           o_Err
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StFlush,
        StWaitDone,
        StOut
    } state_e;

    state_e         state_q, state_d;
    logic [K_W-1:0] cnt_q, cnt_d;
    logic [K_W-1:0] num_q, num_d;
    logic [3:0]     prec_q, prec_d;
    logic           err_q, err_d;
    logic           xfer;
    logic [K_W-1:0] cnt_inc;

`ifdef BBSEQ_DONE_TIMEOUT_EN
    localparam int unsigned TW = $clog2(DONE_TO + 1);
    logic [TW-1:0] timer_q, timer_d;
    logic          to_flag_q, to_flag_d;
`endif

    assign o_Op_Req        = (state_q == StFetch);
    assign xfer            = o_Op_Req & i_Op_Valid;
    assign o_Core_En       = xfer;
    assign o_Core_Sel_Bias = xfer & (cnt_q == '0);
    assign o_Core_Flush    = (state_q == StFlush);
    assign o_Psum_Valid    = (state_q == StOut);
    assign o_Busy          = (state_q != StIdle);
    assign o_Core_Precision = prec_q;
    assign o_Err           = err_q;
    assign cnt_inc         = cnt_q + K_W'(1);

`ifdef BBSEQ_DONE_TIMEOUT_EN
    // Timeout flag shares the counter's MSB so no extra port is needed.
    assign o_Step_Cnt = {cnt_q[K_W-1] | to_flag_q, cnt_q[K_W-2:0]};
`else
    assign o_Step_Cnt = cnt_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        prec_d  = prec_q;
        err_d   = 1'b0;
`ifdef BBSEQ_DONE_TIMEOUT_EN
        timer_d   = timer_q;
        to_flag_d = to_flag_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (i_Start) begin
                    if (i_Num_Step != '0) begin
                        num_d   = i_Num_Step;
                        prec_d  = {i_Act_Prec, i_Wgt_Prec};
                        cnt_d   = '0;
                        state_d = StFetch;
`ifdef BBSEQ_DONE_TIMEOUT_EN
                        to_flag_d = 1'b0;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StFetch: begin
                if (xfer) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == num_q) begin
                        state_d = StFlush;
                    end
                end
            end
            StFlush: begin
                // Done in the flush cycle belongs to no job and is dropped.
                state_d = StWaitDone;
`ifdef BBSEQ_DONE_TIMEOUT_EN
                timer_d = '0;
`endif
            end
            StWaitDone: begin
                if (i_Core_Done) begin
                    state_d = StOut;
                end
`ifdef BBSEQ_DONE_TIMEOUT_EN
                else if (timer_q == TW'(DONE_TO - 1)) begin
                    err_d     = 1'b1;
                    to_flag_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
`endif
            end
            StOut: begin
                if (i_Psum_Ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            num_q   <= '0;
            prec_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            prec_q  <= prec_d;
            err_q   <= err_d;
        end
    end

`ifdef BBSEQ_DONE_TIMEOUT_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            timer_q   <= '0;
            to_flag_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            to_flag_q <= to_flag_d;
        end
    end
`endif

endmodule

// File: tb/tb_bbcore_seq.sv
module tb_bbcore_seq;

    localparam int unsigned K_W = 16;

    logic           CLK = 1'b0;
    logic           RST;
    logic           i_Start;
    logic [K_W-1:0] i_Num_Step;
    logic [1:0]     i_Act_Prec;
    logic [1:0]     i_Wgt_Prec;
    logic           o_Busy;
    logic           o_Op_Req;
    logic           i_Op_Valid;
    logic           o_Core_En;
    logic           o_Core_Sel_Bias;
    logic           o_Core_Flush;
    logic [3:0]     o_Core_Precision;
    logic           i_Core_Done;
    logic           o_Psum_Valid;
    logic           i_Psum_Ready;
    logic [K_W-1:0] o_Step_Cnt;
    logic           o_Err;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    bbcore_seq #(.K_W(K_W), .DONE_TO(64)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .i_Start          (i_Start),
        .i_Num_Step       (i_Num_Step),
        .i_Act_Prec       (i_Act_Prec),
        .i_Wgt_Prec       (i_Wgt_Prec),
        .o_Busy           (o_Busy),
        .o_Op_Req         (o_Op_Req),
        .i_Op_Valid       (i_Op_Valid),
        .o_Core_En        (o_Core_En),
        .o_Core_Sel_Bias  (o_Core_Sel_Bias),
        .o_Core_Flush     (o_Core_Flush),
        .o_Core_Precision (o_Core_Precision),
        .i_Core_Done      (i_Core_Done),
        .o_Psum_Valid     (o_Psum_Valid),
        .i_Psum_Ready     (i_Psum_Ready),
        .o_Step_Cnt       (o_Step_Cnt),
        .o_Err            (o_Err)
    );

    typedef struct {
        int             n;
        logic [1:0]     ap;
        logic [1:0]     wp;
        int             pct;     // valid probability in percent; 0 selects vpat
        logic [15:0]    vpat;    // valid pattern, LSB first
        int             dd;      // WAIT_DONE cycles before done
        int             rd;      // OUT cycles before ready
        logic [K_W-1:0] exp_cnt;
        logic [3:0]     exp_prec;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        i_Start = 1'b0; i_Num_Step = '0; i_Act_Prec = '0; i_Wgt_Prec = '0;
        i_Op_Valid = 1'b0; i_Core_Done = 1'b0; i_Psum_Ready = 1'b0;
    endtask

    // Reference timeline of one job: start cycle, FETCH until n transfers,
    // one flush cycle, dd idle WAIT_DONE cycles, done cycle, rd backpressured
    // OUT cycles, handshake cycle, then IDLE.
    task automatic run_job(input int n, input logic [1:0] ap, input logic [1:0] wp,
                           input int pct, input logic [15:0] vpat, input int dd,
                           input int rd, input logic [K_W-1:0] exp_cnt,
                           input logic [3:0] exp_prec);
        int   beats;
        int   cyc;
        logic v;
        @(negedge CLK);
        idle_inputs();
        i_Start = 1'b1; i_Num_Step = K_W'(n); i_Act_Prec = ap; i_Wgt_Prec = wp;
        #1 chk("start_busy", o_Busy, 0);
        beats = 0;
        cyc   = 0;
        while (beats < n && cyc < 500) begin
            @(negedge CLK);
            // Ignored noise: new starts and precision changes mid-job.
            i_Start    = ($urandom_range(0, 3) == 0);
            i_Num_Step = K_W'($urandom);
            i_Act_Prec = 2'($urandom);
            i_Wgt_Prec = 2'($urandom);
            v = (pct == 0) ? vpat[cyc % 16] : ($urandom_range(1, 100) <= pct);
            i_Op_Valid = v;
            #1;
            chk("fetch_req", o_Op_Req, 1);
            chk("fetch_en", o_Core_En, v);
            chk("fetch_bias", o_Core_Sel_Bias, (v && beats == 0));
            chk("fetch_flush", o_Core_Flush, 0);
            chk("fetch_cnt", o_Step_Cnt, beats);
            chk("fetch_prec", o_Core_Precision, exp_prec);
            if (v) beats++;
            cyc++;
        end
        if (beats < n) begin
            chk("fetch_budget", beats, n);
            return;
        end
        @(negedge CLK);
        i_Start = 1'b0; i_Op_Valid = 1'b1; i_Core_Done = 1'($urandom);
        #1;
        chk("flush_pulse", o_Core_Flush, 1);
        chk("flush_req", o_Op_Req, 0);
        chk("flush_en", o_Core_En, 0);
        chk("flush_cnt", o_Step_Cnt, exp_cnt);
        for (int i = 0; i < dd; i++) begin
            @(negedge CLK);
            i_Core_Done = 1'b0; i_Op_Valid = 1'($urandom);
            #1;
            chk("wait_psum", o_Psum_Valid, 0);
            chk("wait_busy", o_Busy, 1);
            chk("wait_req", o_Op_Req, 0);
            chk("wait_flush", o_Core_Flush, 0);
        end
        @(negedge CLK);
        i_Core_Done = 1'b1;
        #1 chk("done_psum", o_Psum_Valid, 0);
        for (int i = 0; i < rd; i++) begin
            @(negedge CLK);
            i_Core_Done = 1'($urandom); i_Start = 1'($urandom); i_Num_Step = 16'd2;
            i_Psum_Ready = 1'b0;
            #1;
            chk("out_psum", o_Psum_Valid, 1);
            chk("out_busy", o_Busy, 1);
            chk("out_cnt", o_Step_Cnt, exp_cnt);
        end
        @(negedge CLK);
        i_Psum_Ready = 1'b1; i_Start = 1'b1; i_Num_Step = 16'd3; i_Core_Done = 1'b0;
        #1 chk("hs_psum", o_Psum_Valid, 1);
        @(negedge CLK);
        idle_inputs();
        #1;
        chk("idle_busy", o_Busy, 0);
        chk("idle_psum", o_Psum_Valid, 0);
        chk("idle_cnt", o_Step_Cnt, exp_cnt);
        chk("idle_prec", o_Core_Precision, exp_prec);
        chk("idle_err", o_Err, 0);
    endtask

    initial begin
        vecs[0] = '{4, 2'b01, 2'b10, 100, 16'h0000, 2, 0,  16'd4, 4'b0110};
        vecs[1] = '{3, 2'b11, 2'b00, 0,   16'h0029, 0, 1,  16'd3, 4'b1100};
        vecs[2] = '{1, 2'b10, 2'b01, 100, 16'h0000, 1, 2,  16'd1, 4'b1001};
        vecs[3] = '{2, 2'b00, 2'b11, 100, 16'h0000, 3, 10, 16'd2, 4'b0011};
        vecs[4] = '{7, 2'b01, 2'b01, 50,  16'h0000, 0, 0,  16'd7, 4'b0101};

        idle_inputs();
        RST = 1'b0;
        #12;
        chk("rst_busy", o_Busy, 0);
        chk("rst_req", o_Op_Req, 0);
        chk("rst_psum", o_Psum_Valid, 0);
        chk("rst_cnt", o_Step_Cnt, 0);
        chk("rst_prec", o_Core_Precision, 0);
        chk("rst_err", o_Err, 0);
        @(negedge CLK);
        RST = 1'b1;

        foreach (vecs[i]) begin
            run_job(vecs[i].n, vecs[i].ap, vecs[i].wp, vecs[i].pct, vecs[i].vpat,
                    vecs[i].dd, vecs[i].rd, vecs[i].exp_cnt, vecs[i].exp_prec);
        end

        // Zero-length job: error pulse, no activity.
        @(negedge CLK);
        i_Start = 1'b1; i_Num_Step = '0; i_Act_Prec = 2'b11; i_Wgt_Prec = 2'b11;
        #1 chk("zero_err_early", o_Err, 0);
        @(negedge CLK);
        idle_inputs();
        #1;
        chk("zero_err", o_Err, 1);
        chk("zero_busy", o_Busy, 0);
        chk("zero_req", o_Op_Req, 0);
        chk("zero_prec", o_Core_Precision, 4'b0101);
        @(negedge CLK);
        #1;
        chk("zero_err_end", o_Err, 0);
        chk("zero_busy_end", o_Busy, 0);

        // Reset in the middle of FETCH with two beats done.
        @(negedge CLK);
        i_Start = 1'b1; i_Num_Step = 16'd5; i_Act_Prec = 2'b10; i_Wgt_Prec = 2'b10;
        @(negedge CLK);
        i_Start = 1'b0; i_Op_Valid = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        #1 chk("pre_rst_cnt", o_Step_Cnt, 2);
        RST = 1'b0;
        #1;
        chk("mid_rst_busy", o_Busy, 0);
        chk("mid_rst_req", o_Op_Req, 0);
        chk("mid_rst_en", o_Core_En, 0);
        chk("mid_rst_flush", o_Core_Flush, 0);
        chk("mid_rst_cnt", o_Step_Cnt, 0);
        chk("mid_rst_prec", o_Core_Precision, 0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        idle_inputs();
        run_job(2, 2'b11, 2'b01, 100, 16'h0000, 1, 1, 16'd2, 4'b1101);

`ifdef BBSEQ_DONE_TIMEOUT_EN
        // Withheld done: 64 WAIT_DONE cycles, then error pulse and IDLE.
        @(negedge CLK);
        i_Start = 1'b1; i_Num_Step = 16'd1; i_Act_Prec = 2'b01; i_Wgt_Prec = 2'b00;
        @(negedge CLK);
        i_Start = 1'b0; i_Op_Valid = 1'b1;
        @(negedge CLK);
        #1 chk("to_flush", o_Core_Flush, 1);
        for (int i = 0; i < 64; i++) begin
            @(negedge CLK);
            #1;
            chk("to_wait_err", o_Err, 0);
            chk("to_wait_busy", o_Busy, 1);
        end
        @(negedge CLK);
        #1;
        chk("to_err", o_Err, 1);
        chk("to_busy", o_Busy, 0);
        chk("to_psum", o_Psum_Valid, 0);
        chk("to_flag", o_Step_Cnt, 32'h8001);
        run_job(2, 2'b10, 2'b10, 100, 16'h0000, 0, 0, 16'd2, 4'b1010);
`endif

        for (int j = 0; j < 25; j++) begin
            int         n;
            logic [1:0] ap;
            logic [1:0] wp;
            n  = $urandom_range(1, 8);
            ap = 2'($urandom);
            wp = 2'($urandom);
            run_job(n, ap, wp, $urandom_range(30, 100), 16'h0000, $urandom_range(0, 5),
                    $urandom_range(0, 5), K_W'(n), {ap, wp});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
